hazard_stall_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage RV32I pipeline; the producer-side complement to EX-stage forwarding.
- Handles the cases forwarding cannot resolve:
  - load-use hazards: one bubble;
  - multi-cycle data-memory accesses: whole-pipe freeze with timeout;
  - taken-branch flushes.
- Drives enables/bubble selects for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps saturating performance counters.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline hazard logic: opcode constants,
// the stall-controller state encoding and source-register usage decoders.
package pipe_pkg;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   // True when the instruction reads rs1 ([19:15]) as a source operand.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      logic used;
      case (opcode)
         OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: used = 1'b1;
         default:                                                 used = 1'b0;
      endcase
      return used;
   endfunction

   // True when the instruction reads rs2 ([24:20]); I-type immediates that
   // occupy the same bits must not be mistaken for a register read.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      logic used;
      case (opcode)
         OP_OP, OP_STORE, OP_BRANCH: used = 1'b1;
         default:                    used = 1'b0;
      endcase
      return used;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones,
// synchronous clear has priority over counting.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Clear, otherwise increment unless already at the maximum value.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline. Covers the hazards
// forwarding cannot hide: load-use (one bubble), multi-cycle data-memory
// accesses (whole-pipe freeze with timeout to a sticky halt) and taken-branch
// flushes. Control outputs are combinational from the current state and
// inputs so the pipeline registers react in the same cycle.
module hazard_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      Instruction_IFID_out,
   input  logic [31:0]      Instruction_IDEX_out,
   input  logic             MemRead_IDEX_out,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             branch_taken_EX,
   output logic             stall_PC,
   output logic             stall_IFID,
   output logic             stall_IDEX,
   output logic             stall_EXMEM,
   output logic             bubble_IDEX,
   output logic             bubble_MEMWB,
   output logic             flush_IFID,
   output logic             halt,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] memwait_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // One spare bit so the incremented wait count never wraps before the
   // timeout comparison sees it.
   localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;

   logic [6:0]        w_op_id;
   logic [4:0]        w_rs1_id;
   logic [4:0]        w_rs2_id;
   logic [4:0]        w_rd_ex;
   logic              w_rs1_hit;
   logic              w_rs2_hit;
   logic              w_load_use;
   logic              w_mem_stall;
   logic              w_active;
   logic              w_halted;
   logic              w_freeze;
   logic              w_flush;
   logic              w_lu_bubble;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              w_unused;

   // Register fields of the ID-stage consumer and the EX-stage load.
   assign w_op_id  = Instruction_IFID_out[6:0];
   assign w_rs1_id = Instruction_IFID_out[19:15];
   assign w_rs2_id = Instruction_IFID_out[24:20];
   assign w_rd_ex  = Instruction_IDEX_out[11:7];

   // Only real register reads count; x0 is never a true dependency.
   assign w_rs1_hit  = uses_rs1(w_op_id) && (w_rs1_id == w_rd_ex);
   assign w_rs2_hit  = uses_rs2(w_op_id) && (w_rs2_id == w_rd_ex);
   assign w_load_use = MemRead_IDEX_out && (w_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);

   // A same-cycle ack completes the access without any wait.
   assign w_mem_stall = dmem_req && !dmem_ack;

   // Reset masks every control output; HALT overrides all normal decisions.
   assign w_active = !rst && (r_state != HALT);
   assign w_halted = !rst && (r_state == HALT);

   // Priority: memory freeze, then branch flush, then load-use bubble. While
   // frozen the stages hold, so a pending branch or load-use is simply
   // re-evaluated once the freeze releases.
   assign w_freeze    = w_halted || (w_active && w_mem_stall);
   assign w_flush     = w_active && !w_mem_stall && branch_taken_EX;
   assign w_lu_bubble = w_active && !w_mem_stall && !branch_taken_EX && w_load_use;

   assign stall_PC     = w_freeze || w_lu_bubble;
   assign stall_IFID   = w_freeze || w_lu_bubble;
   assign stall_IDEX   = w_freeze;
   assign stall_EXMEM  = w_freeze;
   assign bubble_MEMWB = w_freeze;
   assign bubble_IDEX  = w_flush || w_lu_bubble;
   assign flush_IFID   = w_flush;
   assign halt         = w_halted;

   // The first stalled cycle comes from RUN and counts as wait cycle 1.
   assign w_wait_nxt = (r_state == RUN) ? WAIT_W'(1) : (r_wait_cnt + WAIT_W'(1));

   // State machine: tracks how long the current data-memory access has been
   // waiting and latches HALT once the wait reaches the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            RUN, MEM_WAIT: begin
               if (w_mem_stall) begin
                  r_wait_cnt <= w_wait_nxt;
                  r_state    <= (w_wait_nxt >= WAIT_LIMIT) ? HALT : MEM_WAIT;
               end else begin
                  // Ack or request withdrawn: resume normal operation.
                  r_wait_cnt <= '0;
                  r_state    <= RUN;
               end
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   // Performance counters, cleared by reset and frozen while halted.
   sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_inc (w_lu_bubble),
      .o_cnt (loaduse_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_inc (w_active && w_mem_stall),
      .o_cnt (memwait_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_inc (w_flush),
      .o_cnt (flush_cnt)
   );

   // Instruction bits that the hazard decode does not need.
   assign w_unused = &{1'b0, Instruction_IFID_out[31:25], Instruction_IFID_out[14:7],
                       Instruction_IDEX_out[31:12], Instruction_IDEX_out[6:0]};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_hazard_stall_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CW      = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   ifid;
   logic [31:0]   idex;
   logic          memread;
   logic          dmem_req;
   logic          dmem_ack;
   logic          br;
   logic          stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
   logic          bubble_IDEX, bubble_MEMWB, flush_IFID, halt;
   logic [CW-1:0] loaduse_cnt, memwait_cnt, flush_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;

   localparam logic [31:0] LW_X5   = 32'h0000A283; // lw   x5,0(x1)
   localparam logic [31:0] ADD_X6  = 32'h00228333; // add  x6,x5,x2
   localparam logic [31:0] ADDI_X6 = 32'h00508313; // addi x6,x1,5
   localparam logic [31:0] LW_X0   = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] ADD_X0  = 32'h00200333; // add  x6,x0,x2
   localparam logic [31:0] NOP     = 32'h00000013;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .Instruction_IFID_out (ifid),
      .Instruction_IDEX_out (idex),
      .MemRead_IDEX_out     (memread),
      .dmem_req             (dmem_req),
      .dmem_ack             (dmem_ack),
      .branch_taken_EX      (br),
      .stall_PC             (stall_PC),
      .stall_IFID           (stall_IFID),
      .stall_IDEX           (stall_IDEX),
      .stall_EXMEM          (stall_EXMEM),
      .bubble_IDEX          (bubble_IDEX),
      .bubble_MEMWB         (bubble_MEMWB),
      .flush_IFID           (flush_IFID),
      .halt                 (halt),
      .loaduse_cnt          (loaduse_cnt),
      .memwait_cnt          (memwait_cnt),
      .flush_cnt            (flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifid = NOP; idex = NOP; memread = 1'b0;
      dmem_req = 1'b0; dmem_ack = 1'b0; br = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs();
      dmem_req = 1'b1; br = 1'b1;
      tick(); tick();
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_EXMEM, bubble_MEMWB, flush_IFID, bubble_IDEX, halt} !== 6'b0)
         $display("FAIL rst_outputs_low: got %b want 000000", {stall_PC, stall_EXMEM, bubble_MEMWB, flush_IFID, bubble_IDEX, halt});
      else pass_cnt++;
      rst = 1'b0; idle_inputs();
      tick();
      check_cnt++; if ({loaduse_cnt, memwait_cnt, flush_cnt} !== 12'h000)
         $display("FAIL rst_counters: got %h want 000", {loaduse_cnt, memwait_cnt, flush_cnt});
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      idex = LW_X5; memread = 1'b1; ifid = ADD_X6;
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_IFID, bubble_IDEX, stall_IDEX, flush_IFID} !== 5'b11100)
         $display("FAIL lu_outputs: got %b want 11100", {stall_PC, stall_IFID, bubble_IDEX, stall_IDEX, flush_IFID});
      else pass_cnt++;
      tick();
      check_cnt++; if (loaduse_cnt !== 4'd1)
         $display("FAIL lu_count: got %0d want 1", loaduse_cnt);
      else pass_cnt++;
      // Load has moved on to MEM: the add is now in EX, no more bubble.
      idex = ADD_X6; memread = 1'b0; ifid = NOP;
      @(negedge clk);
      check_cnt++; if ({stall_PC, bubble_IDEX} !== 2'b00)
         $display("FAIL lu_one_cycle: got %b want 00", {stall_PC, bubble_IDEX});
      else pass_cnt++;
      tick();
   endtask

   task automatic test_no_false_stall();
      idex = LW_X5; memread = 1'b1; ifid = ADDI_X6;
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_IFID, bubble_IDEX} !== 3'b000)
         $display("FAIL imm_no_stall: got %b want 000", {stall_PC, stall_IFID, bubble_IDEX});
      else pass_cnt++;
      tick();
      idex = LW_X0; memread = 1'b1; ifid = ADD_X0;
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_IFID, bubble_IDEX} !== 3'b000)
         $display("FAIL x0_no_stall: got %b want 000", {stall_PC, stall_IFID, bubble_IDEX});
      else pass_cnt++;
      tick();
      check_cnt++; if (loaduse_cnt !== 4'd1)
         $display("FAIL no_stall_count: got %0d want 1", loaduse_cnt);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      int frozen = 0;
      dmem_req = 1'b1; dmem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if ({stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, bubble_MEMWB} == 5'b11111) frozen++;
         tick();
      end
      check_cnt++; if (frozen !== 3)
         $display("FAIL memwait_freeze_cycles: got %0d want 3", frozen);
      else pass_cnt++;
      dmem_ack = 1'b1;
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_EXMEM, bubble_MEMWB} !== 3'b000)
         $display("FAIL memwait_release: got %b want 000", {stall_PC, stall_EXMEM, bubble_MEMWB});
      else pass_cnt++;
      tick();
      check_cnt++; if (memwait_cnt !== 4'd3)
         $display("FAIL memwait_count: got %0d want 3", memwait_cnt);
      else pass_cnt++;
      // Zero-wait access: request and ack together.
      dmem_req = 1'b1; dmem_ack = 1'b1;
      @(negedge clk);
      check_cnt++; if ({stall_PC, stall_EXMEM, bubble_MEMWB} !== 3'b000)
         $display("FAIL zero_wait: got %b want 000", {stall_PC, stall_EXMEM, bubble_MEMWB});
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   task automatic test_branch_priority();
      idex = LW_X5; memread = 1'b1; ifid = ADD_X6; br = 1'b1;
      @(negedge clk);
      check_cnt++; if ({flush_IFID, bubble_IDEX, stall_PC, stall_IFID} !== 4'b1100)
         $display("FAIL br_over_lu: got %b want 1100", {flush_IFID, bubble_IDEX, stall_PC, stall_IFID});
      else pass_cnt++;
      tick();
      check_cnt++; if ({flush_cnt, loaduse_cnt} !== {4'd1, 4'd1})
         $display("FAIL br_counts: got flush=%0d lu=%0d want flush=1 lu=1", flush_cnt, loaduse_cnt);
      else pass_cnt++;
      // Memory freeze outranks the branch; the branch acts once ack arrives.
      idle_inputs(); br = 1'b1; dmem_req = 1'b1;
      @(negedge clk);
      check_cnt++; if ({flush_IFID, stall_PC, bubble_MEMWB} !== 3'b011)
         $display("FAIL mem_over_br: got %b want 011", {flush_IFID, stall_PC, bubble_MEMWB});
      else pass_cnt++;
      tick();
      dmem_ack = 1'b1;
      @(negedge clk);
      check_cnt++; if ({flush_IFID, bubble_IDEX, stall_PC} !== 3'b110)
         $display("FAIL br_after_ack: got %b want 110", {flush_IFID, bubble_IDEX, stall_PC});
      else pass_cnt++;
      tick();
      check_cnt++; if ({flush_cnt, memwait_cnt} !== {4'd2, 4'd4})
         $display("FAIL br_ack_counts: got flush=%0d mw=%0d want flush=2 mw=4", flush_cnt, memwait_cnt);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_timeout();
      int early_halt = 0;
      // Request withdrawn after 3 waits: wait counter must restart from zero.
      dmem_req = 1'b1;
      tick(); tick(); tick();
      dmem_req = 1'b0;
      @(negedge clk);
      check_cnt++; if (stall_PC !== 1'b0)
         $display("FAIL req_drop_release: got %b want 0", stall_PC);
      else pass_cnt++;
      tick();
      dmem_req = 1'b1;
      for (int c = 0; c < TIMEOUT; c++) begin
         @(negedge clk);
         if (halt !== 1'b0) early_halt++;
         tick();
      end
      check_cnt++; if (early_halt !== 0)
         $display("FAIL halt_too_early: got %0d early cycles want 0", early_halt);
      else pass_cnt++;
      dmem_req = 1'b0;
      tick(); tick();
      @(negedge clk);
      check_cnt++; if ({halt, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, bubble_MEMWB} !== 6'b111111)
         $display("FAIL halt_sticky: got %b want 111111", {halt, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, bubble_MEMWB});
      else pass_cnt++;
      // memwait: 4 before + 3 dropped-request waits + 4 timeout waits = 11.
      check_cnt++; if (memwait_cnt !== 4'd11)
         $display("FAIL halt_memwait: got %0d want 11", memwait_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_from_halt();
      rst = 1'b1;
      @(negedge clk);
      check_cnt++; if ({halt, stall_PC, bubble_MEMWB} !== 3'b000)
         $display("FAIL rst_in_halt_outputs: got %b want 000", {halt, stall_PC, bubble_MEMWB});
      else pass_cnt++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_cnt++; if ({halt, stall_PC, loaduse_cnt, memwait_cnt, flush_cnt} !== 14'h0)
         $display("FAIL rst_from_halt: got %h want 0", {halt, stall_PC, loaduse_cnt, memwait_cnt, flush_cnt});
      else pass_cnt++;
      // Reset while waiting releases the freeze in that same cycle.
      dmem_req = 1'b1;
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      check_cnt++; if (stall_PC !== 1'b0)
         $display("FAIL rst_mid_wait: got %b want 0", stall_PC);
      else pass_cnt++;
      tick();
      rst = 1'b0; dmem_req = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      idex = LW_X5; memread = 1'b1; ifid = ADD_X6;
      for (int c = 0; c < 20; c++) tick();
      check_cnt++; if (loaduse_cnt !== 4'd15)
         $display("FAIL lu_saturate: got %0d want 15", loaduse_cnt);
      else pass_cnt++;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_mem_wait();
      test_branch_priority();
      test_timeout();
      test_reset_from_halt();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
